mst_rx_sink: RTL and testbench

//  Receive-direction counterpart of the master pre-fetch path. Flow control writes host->FPGA

---
 rtl/mst_rx_sink_pkg.sv | 21 ++
 rtl/mst_rx_sink_if.sv | 28 ++
 rtl/mst_rx_sink_sfifo.sv | 51 +++++
 rtl/mst_rx_sink.sv | 87 ++++++++
 tb/tb_mst_rx_sink.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/mst_rx_sink_pkg.sv
// Shared definitions for the host->FPGA receive sink.
// Holds default geometry and the word packing {be, data} used by flow
// control, the sink FIFO and the channel-0 checker.
package mst_rx_sink_pkg;
  localparam int ADDRBIT_D = 2;   // FIFO address bits
  localparam int DWIDTH_D  = 16;  // data bits per word
  localparam int BEWIDTH_D = 2;   // byte enables per word
  localparam int CNTW_D    = 16;  // delivered-word counter width

  // Word packing: data in the low bits, byte enables on top.
  localparam int DAT_LSB   = 0;
  localparam int BE_LSB    = DWIDTH_D;

  localparam logic [BEWIDTH_D-1:0] BE_ALL = {BEWIDTH_D{1'b1}};

  // Default-width word view, handy for building stimulus.
  typedef struct packed {
    logic [BEWIDTH_D-1:0] be;
    logic [DWIDTH_D-1:0]  data;
  } word_t;
endpackage

// File: rtl/mst_rx_sink_if.sv
// Receive-path bus between flow control (master), the sink, and the
// channel-0 checker. The sink takes the slave modport.
//  rxena/rxwr/rxdin : flow control -> sink write side
//  rxrdy            : sink -> flow control space indication
//  chk0vld/chk0dat  : sink -> checker word
//  chk0ack          : checker -> sink accept
interface mst_rx_sink_if #(
  parameter int DWIDTH  = 16,
  parameter int BEWIDTH = 2
);
  logic                       rxena;
  logic                       rxwr;
  logic [DWIDTH+BEWIDTH-1:0]  rxdin;
  logic                       rxrdy;
  logic                       chk0vld;
  logic [DWIDTH+BEWIDTH-1:0]  chk0dat;
  logic                       chk0ack;

  modport master (
    output rxena, rxwr, rxdin, chk0ack,
    input  rxrdy, chk0vld, chk0dat
  );

  modport slave (
    input  rxena, rxwr, rxdin, chk0ack,
    output rxrdy, chk0vld, chk0dat
  );
endinterface

// File: rtl/mst_rx_sink_sfifo.sv
// Small synchronous FIFO for the receive sink.
//  wr/din   : push (ignored while full)
//  rd/dout  : pop (ignored while empty); dout shows the head word
//  len      : occupancy, ADDRBIT+1 bits so a full FIFO is distinguishable
//  full/empty derived from len
module mst_rx_sink_sfifo #(
  parameter int ADDRBIT = 2,
  parameter int WIDTH   = 18
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr,
  input  logic [WIDTH-1:0]   din,
  input  logic               rd,
  output logic [WIDTH-1:0]   dout,
  output logic [ADDRBIT:0]   len,
  output logic               full,
  output logic               empty
);
  localparam int LENGTH = 1 << ADDRBIT;

  logic [WIDTH-1:0]   mem [LENGTH];
  logic [ADDRBIT-1:0] wrptr, rdptr;
  logic               wr_en, rd_en;

  assign full  = len[ADDRBIT];
  assign empty = (len == '0);
  assign wr_en = wr & ~full;
  assign rd_en = rd & ~empty;
  assign dout  = mem[rdptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LENGTH; i++) mem[i] <= '0;
      wrptr <= '0;
      rdptr <= '0;
      len   <= '0;
    end else begin
      if (wr_en) begin
        mem[wrptr] <= din;
        wrptr      <= wrptr + 1'b1;  // depth is a power of two: natural wrap
      end
      if (rd_en) rdptr <= rdptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   len <= len + 1'b1;
        2'b01:   len <= len - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/mst_rx_sink.sv
// Receive sink: buffers host->FPGA words written by flow control and
// hands them to the channel-0 checker over valid/ack.
//  clk, rst_n : clock, async active-low reset
//  bus        : slave side of mst_rx_sink_if (rx write side + checker side)
//  rxovf      : sticky, a write arrived while the FIFO was full
//  rxpart     : sticky, an accepted word had a partial byte-enable
//  rxcnt      : words delivered to the checker, wraps
module mst_rx_sink
  import mst_rx_sink_pkg::*;
#(
  parameter int ADDRBIT = ADDRBIT_D,
  parameter int LENGTH  = 2 ** ADDRBIT,
  parameter int DWIDTH  = DWIDTH_D,
  parameter int BEWIDTH = BEWIDTH_D,
  parameter int CNTW    = CNTW_D
) (
  input  logic            clk,
  input  logic            rst_n,
  mst_rx_sink_if.slave    bus,
  output logic            rxovf,
  output logic            rxpart,
  output logic [CNTW-1:0] rxcnt
);
  localparam int WW = DWIDTH + BEWIDTH;
  localparam logic [BEWIDTH-1:0] BE_FULL = {BEWIDTH{1'b1}};

  logic [WW-1:0]    fifo_dout;
  logic [ADDRBIT:0] len;
  logic             full, empty;
  logic             wr, load, take;
  logic             vld;
  logic [WW-1:0]    dat;
  logic [BEWIDTH-1:0] be;

  assign be   = bus.rxdin[WW-1:DWIDTH];
  // rxwr is honoured even with rxena low so the in-flight word is kept.
  assign wr   = bus.rxwr & ~full;
  assign take = vld & bus.chk0ack;
  assign load = ~empty & (~vld | bus.chk0ack);

  mst_rx_sink_sfifo #(.ADDRBIT(ADDRBIT), .WIDTH(WW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (bus.rxwr),
    .din   (bus.rxdin),
    .rd    (load),
    .dout  (fifo_dout),
    .len   (len),
    .full  (full),
    .empty (empty)
  );

  // One entry of headroom: flow control may already have a write in flight
  // when it samples rxrdy. Held low during reset.
  assign bus.rxrdy   = rst_n & bus.rxena & (len < (ADDRBIT+1)'(LENGTH-1));
  assign bus.chk0vld = vld;
  assign bus.chk0dat = dat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld    <= 1'b0;
      dat    <= '0;
      rxcnt  <= '0;
      rxovf  <= 1'b0;
      rxpart <= 1'b0;
    end else begin
      // Output register: refill on ack or when idle; data holds when drained.
      if (load) begin
        dat <= fifo_dout;
        vld <= 1'b1;
      end else if (take) begin
        vld <= 1'b0;
      end

      if (take) rxcnt <= rxcnt + 1'b1;

      // An idle cycle with rxena low marks a new session.
      if (!bus.rxena && !bus.rxwr) begin
        rxovf  <= 1'b0;
        rxpart <= 1'b0;
      end else begin
        if (bus.rxwr && full)    rxovf  <= 1'b1;
        if (wr && be != BE_FULL) rxpart <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mst_rx_sink.sv
module tb_mst_rx_sink;
  localparam int CNTW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rxovf, rxpart;
  logic [CNTW-1:0] rxcnt;

  always #5 clk = ~clk;

  mst_rx_sink_if #(.DWIDTH(16), .BEWIDTH(2)) bus ();

  mst_rx_sink #(.ADDRBIT(2), .LENGTH(4), .DWIDTH(16), .BEWIDTH(2), .CNTW(CNTW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus.slave),
    .rxovf  (rxovf),
    .rxpart (rxpart),
    .rxcnt  (rxcnt)
  );

  int tests = 0;
  int fails = 0;

  // Behavioural reference: FIFO contents as a queue plus the output word.
  logic [17:0]     mq[$];
  bit              mv;
  logic [17:0]     md;
  logic [CNTW-1:0] mcnt;
  bit              movf, mpart;
  logic [17:0]     got[$];   // words the DUT handed over (vld & ack)

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [17:0] w(input logic [1:0] be, input logic [15:0] d);
    return {be, d};
  endfunction

  task automatic model_clear();
    mq.delete(); mv = 0; md = '0; mcnt = '0; movf = 0; mpart = 0;
  endtask

  // One clock: drive inputs at negedge, compare, advance the model across the edge.
  task automatic cyc(input bit ena, input bit wr, input logic [17:0] din, input bit ack);
    bit full, acc, dlv, ld;
    @(negedge clk);
    bus.rxena = ena; bus.rxwr = wr; bus.rxdin = din; bus.chk0ack = ack;
    #1;
    chk("vld",  32'(bus.chk0vld), 32'(mv));
    chk("dat",  32'(bus.chk0dat), 32'(md));
    chk("rdy",  32'(bus.rxrdy),   32'(ena && mq.size() < 3));
    chk("ovf",  32'(rxovf),       32'(movf));
    chk("part", 32'(rxpart),      32'(mpart));
    chk("cnt",  32'(rxcnt),       32'(mcnt));
    if (bus.chk0vld && ack) got.push_back(bus.chk0dat);
    full = (mq.size() == 4);
    acc  = wr && !full;
    dlv  = mv && ack;
    ld   = (mq.size() != 0) && (!mv || ack);
    if (dlv) mcnt = mcnt + 1'b1;
    if (!ena && !wr) begin
      movf = 0; mpart = 0;
    end else begin
      if (wr && full) movf = 1;
      if (acc && din[17:16] != 2'b11) mpart = 1;
    end
    if (ld) begin
      md = mq.pop_front(); mv = 1;
    end else if (dlv) mv = 0;
    if (acc) mq.push_back(din);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.rxena = 1'b1; bus.rxwr = 1'b0; bus.rxdin = '0; bus.chk0ack = 1'b0;
    #1;
    chk("rst_vld",  32'(bus.chk0vld), 0);
    chk("rst_dat",  32'(bus.chk0dat), 0);
    chk("rst_rdy",  32'(bus.rxrdy),   0);
    chk("rst_ovf",  32'(rxovf),       0);
    chk("rst_part", 32'(rxpart),      0);
    chk("rst_cnt",  32'(rxcnt),       0);
    model_clear();
    got.delete();
    @(negedge clk);
    bus.rxena = 1'b0;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit          ena, wr;
    logic [17:0] din;
    bit          ack;
    bit          e_vld;
    logic [17:0] e_dat;
    bit          e_rdy;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t tbl[7];

  initial begin
    bus.rxena = 0; bus.rxwr = 0; bus.rxdin = '0; bus.chk0ack = 0;
    model_clear();
    repeat (2) @(posedge clk);
    do_reset();

    // In-order delivery with continuous ack; first vld two cycles after first write.
    tbl[0] = '{1, 1, 18'h30011, 1, 0, 18'h00000, 1, 0};
    tbl[1] = '{1, 1, 18'h30022, 1, 0, 18'h00000, 1, 0};
    tbl[2] = '{1, 1, 18'h30033, 1, 1, 18'h30011, 1, 1 - 1};
    tbl[3] = '{1, 1, 18'h30044, 1, 1, 18'h30022, 1, 1};
    tbl[4] = '{1, 0, 18'h00000, 1, 1, 18'h30033, 1, 2};
    tbl[5] = '{1, 0, 18'h00000, 1, 1, 18'h30044, 1, 3};
    tbl[6] = '{1, 0, 18'h00000, 1, 0, 18'h30044, 1, 4};
    for (int i = 0; i < 7; i++) begin
      cyc(tbl[i].ena, tbl[i].wr, tbl[i].din, tbl[i].ack);
      chk("tbl_vld", 32'(bus.chk0vld), 32'(tbl[i].e_vld));
      chk("tbl_dat", 32'(bus.chk0dat), 32'(tbl[i].e_dat));
      chk("tbl_rdy", 32'(bus.rxrdy),   32'(tbl[i].e_rdy));
      chk("tbl_cnt", 32'(rxcnt),       32'(tbl[i].e_cnt));
    end
    chk("tbl_ovf",  32'(rxovf),  0);
    chk("tbl_part", 32'(rxpart), 0);

    // Overflow: checker stalled, six writes; five survive (output reg + 4).
    do_reset();
    for (int i = 1; i <= 6; i++) cyc(1, 1, w(2'b11, 16'h0100 + 16'(i)), 0);
    cyc(1, 0, '0, 0);
    chk("ovf_rdy",  32'(bus.rxrdy), 0);
    chk("ovf_flag", 32'(rxovf),     1);
    for (int i = 0; i < 10; i++) cyc(1, 0, '0, 1);
    chk("ovf_count", 32'(got.size()), 5);
    for (int i = 0; i < 5 && i < got.size(); i++)
      chk("ovf_order", 32'(got[i]), 32'(w(2'b11, 16'h0101 + 16'(i))));

    // Partial byte-enable word, then a new-session idle cycle clears the flags.
    cyc(0, 0, '0, 1);
    got.delete();
    cyc(1, 1, w(2'b01, 16'hABCD), 1);
    repeat (3) cyc(1, 0, '0, 1);
    chk("part_dat",  (got.size() > 0) ? 32'(got[0]) : 32'hFFFF_FFFF, 32'h1ABCD);
    chk("part_flag", 32'(rxpart), 1);
    cyc(0, 0, '0, 1);
    cyc(1, 0, '0, 0);
    chk("part_clr", 32'(rxpart), 0);

    // Steady state: two words queued, write and load every cycle.
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 1, w(2'b11, 16'h0200 + 16'(i)), 0);
    for (int i = 3; i < 13; i++) begin
      cyc(1, 1, w(2'b11, 16'h0200 + 16'(i)), 1);
      chk("steady_rdy", 32'(bus.rxrdy), 1);
    end
    repeat (6) cyc(1, 0, '0, 1);
    chk("steady_count", 32'(got.size()), 13);
    for (int i = 0; i < 13 && i < got.size(); i++)
      chk("steady_order", 32'(got[i]), 32'(w(2'b11, 16'h0200 + 16'(i))));

    // Counter wrap with a 4-bit counter: 16 deliveries return to zero.
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1, 1, w(2'b11, 16'(i)), 1);
    repeat (4) cyc(1, 0, '0, 1);
    chk("wrap_count", 32'(got.size()), 16);
    chk("wrap_cnt",   32'(rxcnt),      0);

    // Mid-stream reset: output word valid and three words stored.
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 1, w(2'b11, 16'h0300 + 16'(i)), 0);
    cyc(1, 0, '0, 0);
    chk("pre_rst_vld", 32'(bus.chk0vld), 1);
    do_reset();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      bit ena, wr, ack;
      ena = ($urandom_range(0, 9) < 8);
      wr  = ($urandom_range(0, 9) < 6);
      ack = ($urandom_range(0, 1) == 1);
      cyc(ena, wr, 18'($urandom), ack);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
